// File: rtl/status_stack.sv
// rtl/status_stack.sv - condition-flag register with a DEPTH-entry save/restore LIFO
// Define STATUS_STACK_ERR_EN to build the sticky overflow/underflow error flags.
module status_stack #(
  parameter int                FLAG_W      = 4,
  parameter int                DEPTH       = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         load_en_i,
  input  logic [FLAG_W-1:0]            load_mask_i,
  input  logic [FLAG_W-1:0]            flags_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic                         err_clr_i,
  output logic [FLAG_W-1:0]            flags_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         ovf_err_o,
  output logic                         unf_err_o
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d, depth_m1;
  logic              empty_q, empty_d, full_q, full_d;
  logic [FLAG_W-1:0] mem_q [DEPTH];
  logic [FLAG_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_idx, top_idx;
  logic              stk_empty, stk_full, pop_ok, push_ok, swap;

  assign depth_m1 = depth_q - DW'(1);
  assign wr_idx   = depth_q[AW-1:0];
  assign top_idx  = depth_m1[AW-1:0];

  always_comb begin
    stk_empty = (depth_q == '0);
    stk_full  = (depth_q == DW'(DEPTH));
    // Flush swallows push/pop entirely; a pop with push on a non-empty stack is a swap.
    pop_ok    = !flush_i && pop_i && !stk_empty;
    swap      = pop_ok && push_i;
    push_ok   = !flush_i && push_i && !pop_i && !stk_full;

    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = mem_q[top_idx];
    end else if (load_en_i) begin
      flags_d = (flags_q & ~load_mask_i) | (flags_i & load_mask_i);
    end

    mem_d = mem_q;
    if (push_ok) mem_d[wr_idx]  = flags_q;
    if (swap)    mem_d[top_idx] = flags_q;

    depth_d = depth_q;
    if (flush_i)                depth_d = '0;
    else if (push_ok)           depth_d = depth_q + DW'(1);
    else if (pop_ok && !swap)   depth_d = depth_m1;

    empty_d = (depth_d == '0);
    full_d  = (depth_d == DW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= RESET_FLAGS;
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign flags_o = flags_q;
  assign depth_o = depth_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

`ifdef STATUS_STACK_ERR_EN
  logic ovf_err_q, ovf_err_d, unf_err_q, unf_err_d, ovf_set, unf_set;

  always_comb begin
    ovf_set   = !flush_i && push_i && !pop_i && stk_full;
    unf_set   = !flush_i && pop_i && stk_empty;
    ovf_err_d = ovf_set | (ovf_err_q & ~err_clr_i);
    unf_err_d = unf_set | (unf_err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

  assign ovf_err_o = ovf_err_q;
  assign unf_err_o = unf_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign ovf_err_o      = 1'b0;
  assign unf_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_status_stack.sv
// tb/tb_status_stack.sv - randomized self-checking bench for status_stack against a queue-based model
module tb_status_stack;

  localparam int DEPTH = 4;
`ifdef STATUS_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic       load_en, push, pop, flush, err_clr;
  logic [3:0] load_mask, flags_in;
  logic [3:0] flags_out;
  logic [2:0] depth;
  logic       empty, full, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  bit         m_ovf, m_unf;

  status_stack #(.FLAG_W(4), .DEPTH(DEPTH), .RESET_FLAGS(4'b0000)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .load_en_i(load_en), .load_mask_i(load_mask), .flags_i(flags_in),
    .push_i(push), .pop_i(pop), .flush_i(flush), .err_clr_i(err_clr),
    .flags_o(flags_out), .depth_o(depth), .empty_o(empty), .full_o(full),
    .ovf_err_o(ovf_err), .unf_err_o(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_flags = 4'b0000;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one request cycle (inputs set after a falling edge) and advance the model.
  task automatic cyc(input bit ld, input logic [3:0] m, input logic [3:0] fi,
                     input bit pu, input bit po, input bit fl, input bit clr);
    bit ovf_set, unf_set;
    logic [3:0] tmp;
    load_en = ld; load_mask = m; flags_in = fi;
    push = pu; pop = po; flush = fl; err_clr = clr;
    ovf_set = 1'b0; unf_set = 1'b0;
    if (fl) begin
      m_stack.delete();
      if (ld) m_flags = (m_flags & ~m) | (fi & m);
    end else if (po && m_stack.size() > 0) begin
      if (pu) begin
        tmp = m_stack[$];
        m_stack[$] = m_flags;
        m_flags = tmp;
      end else begin
        m_flags = m_stack.pop_back();
      end
    end else begin
      if (po) unf_set = 1'b1;
      if (pu && !po) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
        else ovf_set = 1'b1;
      end
      if (ld) m_flags = (m_flags & ~m) | (fi & m);
    end
    m_ovf = ERR_EN && (ovf_set || (m_ovf && !clr));
    m_unf = ERR_EN && (unf_set || (m_unf && !clr));
    @(posedge clk);
    @(negedge clk);
    load_en = 0; push = 0; pop = 0; flush = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_en = 0; load_mask = 0; flags_in = 0; push = 0; pop = 0; flush = 0; err_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({flags_out, depth, empty, full, ovf_err, unf_err} !== {4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got flags=%b depth=%0d e=%b f=%b o=%b u=%b exp 0000 0 1 0 0 0",
               flags_out, depth, empty, full, ovf_err, unf_err);
    end
  endtask

  task automatic test_load();
    cyc(1, 4'b1111, 4'b1010, 0, 0, 0, 0);
    checks++;
    if (flags_out !== 4'b1010 || depth !== 3'd0) begin
      errors++; $display("FAIL load_full got %b/%0d exp 1010/0", flags_out, depth);
    end
    cyc(1, 4'b0011, 4'b0101, 0, 0, 0, 0);
    checks++;
    if (flags_out !== 4'b1001) begin
      errors++; $display("FAIL load_mask got %b exp 1001", flags_out);
    end
  endtask

  task automatic test_push_load();
    cyc(1, 4'b1111, 4'b0110, 1, 0, 0, 0);
    checks++;
    if (flags_out !== 4'b0110 || depth !== 3'd1) begin
      errors++; $display("FAIL push_load got %b/%0d exp 0110/1", flags_out, depth);
    end
    cyc(1, 4'b1111, 4'b1111, 0, 1, 0, 0);
    checks++;
    if (flags_out !== 4'b1001 || depth !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL pop_restore got %b/%0d/%b exp 1001/0/1", flags_out, depth, empty);
    end
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 5; v++) begin
      cyc(1, 4'b1111, 4'(v), 0, 0, 0, 0);
      cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
      if (v == 4) begin
        checks++;
        if (full !== 1'b1 || depth !== 3'd4) begin
          errors++; $display("FAIL full got full=%b depth=%0d exp 1/4", full, depth);
        end
      end
    end
    checks++;
    if (depth !== 3'd4 || ovf_err !== ERR_EN || flags_out !== 4'd5) begin
      errors++; $display("FAIL overflow got depth=%0d ovf=%b flags=%0d exp 4/%b/5", depth, ovf_err, flags_out, ERR_EN);
    end
    for (int v = 4; v >= 1; v--) begin
      cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
      checks++;
      if (flags_out !== 4'(v) || depth !== 3'(v - 1)) begin
        errors++; $display("FAIL pop_order got %0d/%0d exp %0d/%0d", flags_out, depth, v, v - 1);
      end
    end
    cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL err_clr got ovf=%b exp 0", ovf_err);
    end
  endtask

  task automatic test_underflow_swap();
    cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    checks++;
    if (unf_err !== ERR_EN || flags_out !== 4'b0001 || depth !== 3'd0) begin
      errors++; $display("FAIL underflow got unf=%b flags=%b depth=%0d exp %b/0001/0", unf_err, flags_out, depth, ERR_EN);
    end
    cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    cyc(1, 4'b1111, 4'b1000, 0, 0, 0, 0);
    cyc(1, 4'b1111, 4'b0111, 1, 1, 0, 0);
    checks++;
    if (flags_out !== 4'b0001 || depth !== 3'd1 || unf_err !== 1'b0 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL swap got flags=%b depth=%0d exp 0001/1", flags_out, depth);
    end
    cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    checks++;
    if (flags_out !== 4'b1000 || depth !== 3'd0) begin
      errors++; $display("FAIL swap_top got flags=%b depth=%0d exp 1000/0", flags_out, depth);
    end
  endtask

  task automatic test_flush();
    cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    cyc(1, 4'b1111, 4'b0011, 1, 0, 1, 0);
    checks++;
    if (depth !== 3'd0 || empty !== 1'b1 || ovf_err !== 1'b0 || unf_err !== 1'b0 || flags_out !== 4'b0011) begin
      errors++; $display("FAIL flush got depth=%0d e=%b o=%b u=%b flags=%b exp 0/1/0/0/0011",
                         depth, empty, ovf_err, unf_err, flags_out);
    end
  endtask

  task automatic test_random();
    bit ld, pu, po, fl, clr;
    logic [3:0] m, fi;
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 1) == 1);
      pu  = ($urandom_range(0, 9) < 5);
      po  = ($urandom_range(0, 9) < 4);
      fl  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 9) == 0);
      m   = 4'($urandom);
      fi  = 4'($urandom);
      cyc(ld, m, fi, pu, po, fl, clr);
      checks++;
      if (flags_out !== m_flags || depth !== 3'(m_stack.size()) ||
          empty !== (m_stack.size() == 0) || full !== (m_stack.size() == DEPTH) ||
          ovf_err !== m_ovf || unf_err !== m_unf) begin
        errors++;
        $display("FAIL random[%0d] got flags=%b depth=%0d e=%b f=%b o=%b u=%b exp %b/%0d/%b/%b/%b/%b",
                 i, flags_out, depth, empty, full, ovf_err, unf_err, m_flags, m_stack.size(),
                 m_stack.size() == 0, m_stack.size() == DEPTH, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 4'b1111, 4'b1111, 1, 0, 0, 0);
    cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({flags_out, depth, empty, full, ovf_err, unf_err} !== {4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got flags=%b depth=%0d e=%b f=%b o=%b u=%b exp 0000 0 1 0 0 0",
               flags_out, depth, empty, full, ovf_err, unf_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    checks++;
    if (depth !== 3'd0 || unf_err !== ERR_EN || flags_out !== 4'b0000) begin
      errors++; $display("FAIL post_reset_pop got depth=%0d unf=%b flags=%b exp 0/%b/0000", depth, unf_err, flags_out, ERR_EN);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_push_load();
    test_overflow();
    test_underflow_swap();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_stack.md
# status_stack

Parametrised processor status register with a hardware save/restore stack. It holds the FLAG_W-bit condition flags (ZNCV by default) behind a per-bit write mask and adds a DEPTH-entry LIFO so that flags can be pushed on interrupt or call entry and popped on return. It sits between the ALU flag outputs and the control unit, and replaces the single-load flag latch in the datapath.

## Interface
- FLAG_W, 4, flag width; bit order {Z,N,C,V} at the default width.
- DEPTH, 4, number of stack entries (≥1).
- RESET_FLAGS, '0, value of flags_o after reset.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- load_en_i  input  1  load flags from flags_i under load_mask_i.
- load_mask_i  input  FLAG_W  per-bit load enable; 1 means the bit takes flags_i.
- flags_i  input  FLAG_W  new flag values (ALU ZNCV).
- push_i  input  1  save current flags onto the stack.
- pop_i  input  1  restore flags from the top of the stack.
- flush_i  input  1  discard all stack entries.
- err_clr_i  input  1  clear the sticky error flags.
- flags_o  output  FLAG_W  current flags, registered.
- depth_o  output  $clog2(DEPTH+1)  number of valid stack entries.
- empty_o  output  1  depth_o == 0.
- full_o  output  1  depth_o == DEPTH.
- ovf_err_o  output  1  sticky flag: a push was attempted while full.
- unf_err_o  output  1  sticky flag: a pop was attempted while empty.

## Operation
- Reset: flags_o = RESET_FLAGS, depth_o = 0, empty_o = 1, full_o = 0, ovf_err_o = 0, unf_err_o = 0. Stack contents are don't-care.
- Load only: flags <= (flags & ~load_mask_i) | (flags_i & load_mask_i).
- Push only, not full:
  - mem[depth] <= flags, using the pre-edge value.
  - depth += 1.
  - A load in the same cycle is still applied to flags, so the pushed value is the old flags and flags_o takes the new ones.
- Pop only, not empty:
  - flags <= mem[depth-1].
  - depth -= 1.
  - A load in the same cycle is ignored because pop wins.
- Push and pop together, not empty: swap.
  - flags <= mem[depth-1] and mem[depth-1] <= flags.
  - depth is unchanged and load is ignored.
- Push and pop together while empty: both are ignored, unf_err set, and a load still applies.
- Push while full: the push is ignored and ovf_err is set. A load still applies.
- Pop while empty: the pop is ignored and unf_err is set. A load applies.
- flush_i: depth <= 0.
  - It has priority over push and pop in the same cycle; those are ignored and raise no error.
  - A load still applies.
- err_clr_i: clears both error flags. A new error raised in the same cycle wins, so that flag stays 1.
- Width: depth is tracked as an unsigned counter in 0..DEPTH. The stack pointer never wraps.

## Timing
- Every output is registered. An effect is visible on the cycle after the sampling edge, i.e. latency is 1.
- There are no combinational paths from inputs to outputs.
- There is no handshake. Every request is accepted or rejected in the cycle it is presented.
- Reset is asynchronous. Asserting it mid-sequence immediately drives all outputs to their reset values, and the stack becomes empty.
- Back-to-back pushes or pops are sustained at one per cycle.

## Configuration
- STATUS_STACK_ERR_EN
  - Defined: the sticky ovf_err_o and unf_err_o registers are built as described above.
  - Undefined: ovf_err_o and unf_err_o are tied to 0 and err_clr_i is unused. Illegal push and pop are still silently ignored, with identical effect on flags and depth.

## Test plan
- Reset, then load_en=1, mask=4'b1111, flags_i=4'b1010 → next cycle flags_o=4'b1010 and depth_o=0.
- flags=4'b1010, then load mask=4'b0011, flags_i=4'b0101 → flags_o=4'b1001.
- flags=4'b1001. Push together with a load of flags_i=4'b0110 under mask 4'b1111 → flags_o=4'b0110, depth_o=1. Then pop → flags_o=4'b1001, depth_o=0, empty_o=1.
- DEPTH=4: push five times with flags 1, 2, 3, 4, 5.
  - After the fourth push, full_o=1.
  - The fifth push is ignored: depth_o stays 4 and ovf_err_o=1.
  - Four pops then return flags 4, 3, 2, 1.
  - err_clr → ovf_err_o=0.
- Empty stack, pop → unf_err_o=1 and flags unchanged. Then push 4'b0001, set flags to 4'b1000, and push+pop together → flags_o=4'b0001, top entry=4'b1000, depth_o=1.
- Two entries, then flush together with push → depth_o=0, no error. Assert rst_ni low mid-stream → all outputs return to reset values asynchronously.
